cpu_clk_ctrl: RTL and testbench



---
 rtl/cpu_clk_ctrl_pkg.sv | 15 +
 rtl/ce_period_cnt.sv | 33 +++
 rtl/cpu_clk_ctrl.sv | 111 +++++++++++
 tb/tb_cpu_clk_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared state encoding and default widths for the CPU clock-enable scheduler.
// No logic, no latency, no backpressure.
package cpu_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BURST = 2'd3
  } clk_state_t;

  localparam int CLK_CTRL_DIV_W   = 8;
  localparam int CLK_CTRL_BURST_W = 8;

endpackage

// File: rtl/ce_period_cnt.sv
// Period counter: tick every div_q+1 active cycles, tick decoded from registers only.
// div_q reloads only at clear or tick so a ratio change never produces a runt period.
module ce_period_cnt
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int DIV_W = CLK_CTRL_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             active,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;

  assign tick = active && (cnt == div_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (clear || tick) begin
      cnt   <= '0;
      div_q <= div_val;
    end else if (active) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable scheduler: run / single-step / burst (CPU_CLK_CTRL_BURST_EN) modes.
// cpu_ce is register-decoded (no input-to-output path); requests outside IDLE are dropped.
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
`ifdef CPU_CLK_CTRL_BURST_EN
  parameter int BURST_W = CLK_CTRL_BURST_W,
`endif
  parameter int DIV_W = CLK_CTRL_DIV_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run_req,
  input  logic               halt_req,
  input  logic               step_req,
`ifdef CPU_CLK_CTRL_BURST_EN
  input  logic               burst_req,
  input  logic [BURST_W-1:0] burst_len,
`endif
  input  logic [DIV_W-1:0]   div_val,
  output logic               cpu_ce,
  output logic               clk_out,
  output logic [1:0]         state,
  output logic               busy
);

  clk_state_t state_q;
  clk_state_t state_d;
  logic       tick;
  logic       cnt_active;
  logic       cnt_clear;

`ifdef CPU_CLK_CTRL_BURST_EN
  logic [BURST_W-1:0] remain;
`endif

  ce_period_cnt #(.DIV_W(DIV_W)) u_period (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .active  (cnt_active),
    .div_val (div_val),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      clk_out <= clk_out ^ tick;
    end
  end

  always_comb begin
    state_d = state_q;
    if (halt_req) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (step_req)       state_d = STEP;
`ifdef CPU_CLK_CTRL_BURST_EN
          else if (burst_req) state_d = BURST;
`endif
          else if (run_req)   state_d = RUN;
        end
        RUN:  if (!run_req) state_d = IDLE;
        STEP: if (tick)     state_d = IDLE;
`ifdef CPU_CLK_CTRL_BURST_EN
        BURST: begin
          // a zero-length burst leaves without ever ticking
          if (remain == '0 || (tick && remain == BURST_W'(1))) state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_active = 1'b0;
    case (state_q)
      RUN, STEP: cnt_active = 1'b1;
`ifdef CPU_CLK_CTRL_BURST_EN
      BURST:     cnt_active = (remain != '0);
`endif
      default:   cnt_active = 1'b0;
    endcase
  end

  assign cnt_clear = (state_q == IDLE) && (state_d != IDLE);
  assign cpu_ce    = tick;
  assign state     = state_q;

`ifdef CPU_CLK_CTRL_BURST_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      remain <= '0;
    end else if (state_q == IDLE && state_d == BURST) begin
      remain <= burst_len;
    end else if (state_q == BURST && tick) begin
      remain <= remain - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: vector table, directed corner sequences, then random
// stimulus against a countdown-based reference model.
module tb_cpu_clk_ctrl;
  import cpu_clk_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset, run_req, halt_req, step_req;
  logic [7:0] div_val;
  logic       cpu_ce, clk_out, busy;
  logic [1:0] state;
`ifdef CPU_CLK_CTRL_BURST_EN
  logic       burst_req;
  logic [7:0] burst_len;
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_clk_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .run_req  (run_req),
    .halt_req (halt_req),
    .step_req (step_req),
`ifdef CPU_CLK_CTRL_BURST_EN
    .burst_req(burst_req),
    .burst_len(burst_len),
`endif
    .div_val  (div_val),
    .cpu_ce   (cpu_ce),
    .clk_out  (clk_out),
    .state    (state),
    .busy     (busy)
  );

  typedef struct {
    logic       run, halt, step;
    logic [7:0] div;
    logic       ce;
    logic [1:0] st;
    logic       bsy, co;
  } vec_t;

  function automatic vec_t mk(input logic run, input logic halt, input logic step,
                              input logic [7:0] div, input logic ce, input logic [1:0] st,
                              input logic bsy, input logic co);
    vec_t v;
    v.run = run; v.halt = halt; v.step = step; v.div = div;
    v.ce = ce; v.st = st; v.bsy = bsy; v.co = co;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // sample this cycle's outputs at the falling edge, then step past the next rising edge
  task automatic cyc(output logic ce_s, output logic co_s, output logic [1:0] st_s);
    @(negedge clk);
    ce_s = cpu_ce; co_s = clk_out; st_s = state;
    @(posedge clk); #1;
  endtask

  // Reference model: mode plus "cycles left until the next pulse" countdown.
  int   m_mode, m_left, m_rem;
  logic m_clk;

  function automatic logic m_active();
    return (m_mode == 1) || (m_mode == 2) || (m_mode == 3 && m_rem > 0);
  endfunction

  function automatic logic m_pulse();
    return m_active() && (m_left == 0);
  endfunction

  function automatic void m_step(input logic rst, input logic run, input logic halt,
                                 input logic step, input logic burst, input int blen,
                                 input int div);
    int   nm;
    logic act, ce;
    if (rst) begin
      m_mode = 0; m_left = 0; m_rem = 0; m_clk = 1'b0;
      return;
    end
    act = m_active();
    ce  = m_pulse();
    nm  = m_mode;
    if (halt) nm = 0;
    else begin
      case (m_mode)
        0: begin
          if (step) nm = 2;
          else if (BURST_EN && burst) begin nm = 3; m_rem = blen; end
          else if (run) nm = 1;
        end
        1: if (!run) nm = 0;
        2: if (ce) nm = 0;
        default: if (m_rem == 0 || (ce && m_rem == 1)) nm = 0;
      endcase
    end
    if (m_mode == 3 && ce) m_rem = m_rem - 1;
    if (m_mode == 0 && nm != 0) m_left = div;
    else if (ce)                m_left = div;
    else if (act)               m_left = m_left - 1;
    if (ce) m_clk = ~m_clk;
    m_mode = nm;
  endfunction

  initial begin
    logic       s_ce, s_co, co0;
    logic [1:0] s_st;
    int         p[5];
    int         np, tog;
    vec_t       tbl[20];
    logic       r_burst;
    int         r_blen;

    //            run halt step div  ce st bsy co
    tbl[0]  = mk(0, 0, 1, 8'd3, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 8'd3, 0, 2, 1, 0);
    tbl[2]  = mk(0, 0, 0, 8'd3, 0, 2, 1, 0);
    tbl[3]  = mk(0, 0, 0, 8'd3, 0, 2, 1, 0);
    tbl[4]  = mk(0, 0, 0, 8'd3, 1, 2, 1, 0);
    tbl[5]  = mk(0, 0, 1, 8'd0, 0, 0, 0, 1);
    tbl[6]  = mk(0, 0, 0, 8'd0, 1, 2, 1, 1);
    tbl[7]  = mk(1, 0, 1, 8'd1, 0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 8'd1, 0, 2, 1, 0);
    tbl[9]  = mk(0, 0, 0, 8'd1, 1, 2, 1, 0);
    tbl[10] = mk(0, 0, 0, 8'd1, 0, 0, 0, 1);
    tbl[11] = mk(0, 0, 0, 8'd1, 0, 0, 0, 1);
    tbl[12] = mk(1, 0, 0, 8'd1, 0, 0, 0, 1);
    tbl[13] = mk(1, 0, 0, 8'd1, 0, 1, 1, 1);
    tbl[14] = mk(1, 0, 0, 8'd1, 1, 1, 1, 1);
    tbl[15] = mk(1, 0, 0, 8'd1, 0, 1, 1, 0);
    tbl[16] = mk(1, 1, 0, 8'd1, 1, 1, 1, 0);
    tbl[17] = mk(0, 0, 0, 8'd1, 0, 0, 0, 1);
    tbl[18] = mk(0, 1, 1, 8'd1, 0, 0, 0, 1);
    tbl[19] = mk(0, 0, 0, 8'd1, 0, 0, 0, 1);

    reset = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; div_val = 8'd0;
`ifdef CPU_CLK_CTRL_BURST_EN
    burst_req = 1'b0; burst_len = 8'd0;
`endif
    repeat (2) @(posedge clk);
    #1;

    // reset in the middle of RUN, after one pulse has left clk_out high
    reset = 1'b0; run_req = 1'b1; div_val = 8'd2;
    repeat (5) cyc(s_ce, s_co, s_st);
    reset = 1'b1;
    @(negedge clk);
    chk("pre_reset_clk_out", clk_out, 1);
    chk("pre_reset_busy", busy, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0; run_req = 1'b0;
    @(negedge clk);
    chk("reset_cpu_ce", cpu_ce, 0);
    chk("reset_clk_out", clk_out, 0);
    chk("reset_state", state, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      run_req = tbl[i].run; halt_req = tbl[i].halt; step_req = tbl[i].step; div_val = tbl[i].div;
      @(negedge clk);
      chk($sformatf("vec%0d_ce", i), cpu_ce, tbl[i].ce);
      chk($sformatf("vec%0d_state", i), state, tbl[i].st);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("vec%0d_clk_out", i), clk_out, tbl[i].co);
      @(posedge clk); #1;
    end
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;

    // ratio change mid-period: current period keeps the old ratio
    run_req = 1'b1; div_val = 8'd1; np = 0;
    for (int i = 0; i < 40 && np < 5; i++) begin
      cyc(s_ce, s_co, s_st);
      if (s_ce) begin
        p[np] = i;
        np++;
        if (np == 2) div_val = 8'd4;
      end
    end
    chk("ratio_pulse_count", np, 5);
    if (np == 5) begin
      chk("ratio_gap1", p[1] - p[0], 2);
      chk("ratio_gap2", p[2] - p[1], 2);
      chk("ratio_gap3", p[3] - p[2], 5);
      chk("ratio_gap4", p[4] - p[3], 5);
    end
    run_req = 1'b0;
    cyc(s_ce, s_co, s_st);
    @(negedge clk);
    chk("run_drop_state", state, 0);
    chk("run_drop_busy", busy, 0);
    @(posedge clk); #1;

`ifdef CPU_CLK_CTRL_BURST_EN
    div_val = 8'd0; burst_len = 8'd3; burst_req = 1'b1;
    cyc(s_ce, s_co, s_st);
    co0 = s_co; burst_req = 1'b0; tog = 0;
    for (int j = 1; j <= 5; j++) begin
      cyc(s_ce, s_co, s_st);
      chk($sformatf("burst3_ce%0d", j), s_ce, (j <= 3));
      if (j == 4) chk("burst3_idle", s_st, 0);
      if (s_co !== co0) tog++;
      co0 = s_co;
    end
    chk("burst3_toggles", tog, 3);

    burst_len = 8'd0; burst_req = 1'b1;
    cyc(s_ce, s_co, s_st);
    burst_req = 1'b0;
    cyc(s_ce, s_co, s_st);
    chk("burst0_state1", s_st, 3);
    chk("burst0_ce1", s_ce, 0);
    cyc(s_ce, s_co, s_st);
    chk("burst0_state2", s_st, 0);
    chk("burst0_ce2", s_ce, 0);
`else
    // encoding 3 does not exist without bursts; it must fall back to IDLE silently
    force dut.state_q = BURST;
    @(negedge clk);
    chk("forced_state", state, 3);
    chk("forced_ce", cpu_ce, 0);
    release dut.state_q;
    @(posedge clk); #1;
    @(negedge clk);
    chk("forced_recover_state", state, 0);
    chk("forced_recover_busy", busy, 0);
    chk("forced_recover_ce", cpu_ce, 0);
    @(posedge clk); #1;
`endif

    // random phase against the model
    reset = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    @(negedge clk);
    m_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) run_req = ~run_req;
      halt_req = ($urandom_range(0, 24) == 0);
      step_req = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) div_val = 8'($urandom_range(0, 4));
      r_burst = 1'b0; r_blen = 0;
`ifdef CPU_CLK_CTRL_BURST_EN
      burst_req = ($urandom_range(0, 7) == 0);
      burst_len = 8'($urandom_range(0, 4));
      r_burst = burst_req; r_blen = int'(burst_len);
`endif
      @(negedge clk);
      chk($sformatf("rnd%0d_ce", i), cpu_ce, m_pulse());
      chk($sformatf("rnd%0d_state", i), state, m_mode);
      chk($sformatf("rnd%0d_busy", i), busy, (m_mode != 0));
      chk($sformatf("rnd%0d_clk_out", i), clk_out, m_clk);
      m_step(reset, run_req, halt_req, step_req, r_burst, r_blen, int'(div_val));
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
